// File: rtl/vcap_pkg.sv
// vcap_pkg: shared constants and types for the video capture front end.
//   H_ACTIVE_DEF / V_ACTIVE_DEF : default active field size (720 x 240)
//   H_OUT / V_OUT               : decimated output size (180 x 120)
//   H_DECIM / V_DECIM           : decimation factors (4 horizontal, 2 vertical)
//   cap_state_e                 : capture FSM states
package vcap_pkg;

    localparam int H_ACTIVE_DEF = 720;
    localparam int V_ACTIVE_DEF = 240;
    localparam int H_OUT        = 180;
    localparam int V_OUT        = 120;
    localparam int H_DECIM      = 4;
    localparam int V_DECIM      = 2;

    typedef enum logic [1:0] {
        ST_WAIT_VS = 2'd0,
        ST_WAIT_HS = 2'd1,
        ST_LINE    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/vcap_hdecim.sv
// vcap_hdecim: 4:1 horizontal group collector.
// Latches Cb at group phase 0 and Cr at phase 1, and produces the luma value
// and an emit strobe on phase 3. The emitted values are combinational here and
// registered by the parent.
// Configuration macro VCAP_LUMA_AVG_EN: when defined, luma is the rounded mean
// of the four samples; otherwise luma is the phase-0 sample.
// Ports:
//   clk_llc2, resetx : pixel clock, async active-low reset
//   i_act            : a valid pixel sample is present this cycle
//   i_idx            : pixel index within the line
//   i_cap            : current line is captured
//   i_y, i_c         : luma and chroma of the current sample
//   o_emit           : group complete, output pixel valid
//   o_y, o_cb, o_cr  : decimated pixel components
module vcap_hdecim
    import vcap_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int HW       = 10
) (
    input  logic          clk_llc2,
    input  logic          resetx,
    input  logic          i_act,
    input  logic [HW-1:0] i_idx,
    input  logic          i_cap,
    input  logic [7:0]    i_y,
    input  logic [7:0]    i_c,
    output logic          o_emit,
    output logic [7:0]    o_y,
    output logic [7:0]    o_cb,
    output logic [7:0]    o_cr
);

    localparam logic [HW-1:0] H_LIM = HW'(H_ACTIVE);

    logic [1:0] w_phase;
    logic [7:0] r_cb;
    logic [7:0] r_cr;

    assign w_phase = i_idx[1:0];
    // Samples past the active width never complete a group.
    assign o_emit  = i_act & i_cap & (w_phase == 2'd3) & (i_idx < H_LIM);
    assign o_cb    = r_cb;
    assign o_cr    = r_cr;

    // Chroma latch: Cb rides on even samples, Cr on odd ones.
    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            r_cb <= 8'd0;
            r_cr <= 8'd0;
        end else if (i_act) begin
            case (w_phase)
                2'd0:    r_cb <= i_c;
                2'd1:    r_cr <= i_c;
                default: r_cb <= r_cb;
            endcase
        end
    end

`ifdef VCAP_LUMA_AVG_EN
    logic [9:0] r_acc;
    logic [9:0] w_sum;

    // Running luma sum of phases 0..2; phase 3 is added combinationally.
    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            r_acc <= 10'd0;
        end else if (i_act) begin
            case (w_phase)
                2'd0:       r_acc <= {2'b00, i_y};
                2'd1, 2'd2: r_acc <= r_acc + {2'b00, i_y};
                default:    r_acc <= r_acc;
            endcase
        end
    end

    // Max 4*255+2 = 1022, so the 10-bit sum cannot overflow.
    assign w_sum = r_acc + {2'b00, i_y} + 10'd2;
    assign o_y   = w_sum[9:2];
`else
    logic [7:0] r_y;

    // Luma of the first sample in each group.
    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            r_y <= 8'd0;
        end else if (i_act && (w_phase == 2'd0)) begin
            r_y <= i_y;
        end
    end

    assign o_y = r_y;
`endif

endmodule

// File: rtl/vcap_field_decimator.sv
// vcap_field_decimator: SAA7111A capture front end.
// Registers decoder pins, captures odd fields only, keeps every second line and
// every fourth pixel group, and emits a coordinate-tagged pixel stream with
// sof/eol/eof markers and a malformed-line pulse.
// Configuration macro VCAP_LUMA_AVG_EN (in vcap_hdecim): 4-sample luma average.
// Ports:
//   clk_llc2, resetx            : pixel clock, async active-low reset
//   i_vref, i_href, i_odd       : decoder sync / field flag
//   i_vpo[15:0]                 : Y in [15:8], alternating Cb/Cr in [7:0]
//   o_pix_valid                 : one-cycle output pixel strobe
//   o_pix_y/cb/cr, o_pix_x,
//   o_pix_line                  : pixel components and coordinates (held)
//   o_sof, o_eol                : first pixel of field / last pixel of row
//   o_eof                       : end of captured field
//   o_line_err                  : short or long captured line
//   o_field_cnt                 : captured field counter (wraps)
module vcap_field_decimator
    import vcap_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic        clk_llc2,
    input  logic        resetx,
    input  logic        i_vref,
    input  logic        i_href,
    input  logic        i_odd,
    input  logic [15:0] i_vpo,
    output logic        o_pix_valid,
    output logic [7:0]  o_pix_y,
    output logic [7:0]  o_pix_cb,
    output logic [7:0]  o_pix_cr,
    output logic [7:0]  o_pix_x,
    output logic [6:0]  o_pix_line,
    output logic        o_sof,
    output logic        o_eol,
    output logic        o_eof,
    output logic        o_line_err,
    output logic [7:0]  o_field_cnt
);

    // hcnt saturates at H_ACTIVE+1 so the long-line index H_ACTIVE is seen once.
    localparam int HW = $clog2(H_ACTIVE + 2);
    localparam int VW = $clog2(V_ACTIVE + 1);
    localparam logic [HW-1:0] H_LIM  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_LIM  = VW'(V_ACTIVE);
    localparam logic [7:0]    X_LAST = 8'(H_ACTIVE / H_DECIM - 1);

    logic        r_vref, r_href, r_odd, r_vref_d, r_href_d;
    logic [15:0] r_vpo;
    logic [1:0]  r_vld;
    cap_state_e  r_state, w_next;
    logic [HW-1:0] r_hcnt, w_hidx;
    logic [VW-1:0] r_vcnt;
    logic        r_cap, r_eof_pend;
    logic [6:0]  r_line;
    logic        w_vrise, w_vfall, w_hrise, w_act, w_line_start;
    logic        w_vend, w_lerr, w_eof_now, w_emit;
    logic [7:0]  w_x, w_y, w_cb, w_cr;

    // Input stage plus one-cycle history for edge detection.
    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            r_vref   <= 1'b0;
            r_href   <= 1'b0;
            r_odd    <= 1'b0;
            r_vpo    <= 16'd0;
            r_vref_d <= 1'b0;
            r_href_d <= 1'b0;
            r_vld    <= 2'b00;
        end else begin
            r_vref   <= i_vref;
            r_href   <= i_href;
            r_odd    <= i_odd;
            r_vpo    <= i_vpo;
            r_vref_d <= r_vref;
            r_href_d <= r_href;
            r_vld    <= {r_vld[0], 1'b1};
        end
    end

    // vref edges only count once both history taps hold real pin samples, so a
    // reset released mid-field cannot fake a rising edge.
    assign w_vrise = r_vref & ~r_vref_d & r_vld[1];
    assign w_vfall = ~r_vref & r_vref_d & r_vld[1];
    assign w_hrise = r_href & ~r_href_d;
    assign w_vend  = w_vfall & (r_state != ST_WAIT_VS);

    // Next-state logic; the href rising cycle already carries pixel 0.
    always_comb begin
        w_next       = r_state;
        w_act        = 1'b0;
        w_hidx       = r_hcnt;
        w_line_start = 1'b0;
        case (r_state)
            ST_WAIT_VS: begin
                if (w_vrise && r_odd) w_next = ST_WAIT_HS;
                else                  w_next = ST_WAIT_VS;
            end
            ST_WAIT_HS: begin
                if (w_vfall) begin
                    w_next = ST_WAIT_VS;
                end else if (w_hrise) begin
                    w_next       = ST_LINE;
                    w_act        = 1'b1;
                    w_hidx       = '0;
                    w_line_start = 1'b1;
                end else begin
                    w_next = ST_WAIT_HS;
                end
            end
            ST_LINE: begin
                // A sample arriving with the vref fall is still processed.
                w_act = r_href;
                if (w_vfall)      w_next = ST_WAIT_VS;
                else if (!r_href) w_next = ST_WAIT_HS;
                else              w_next = ST_LINE;
            end
            default: w_next = ST_WAIT_VS;
        endcase
    end

    // Short line at href fall or long line at index H_ACTIVE; vref abort is silent.
    assign w_lerr = r_cap & ~w_vfall &
                    (((r_state == ST_LINE) & ~r_href & (r_hcnt < H_LIM)) |
                     (w_act & (w_hidx == H_LIM)));
    // If the last pixel shares the vref-fall cycle, eof slips one cycle behind it.
    assign w_eof_now = (w_vend & ~w_emit) | r_eof_pend;
    assign w_x       = 8'(w_hidx >> 2);

    vcap_hdecim #(
        .H_ACTIVE (H_ACTIVE),
        .HW       (HW)
    ) u_hdecim (
        .clk_llc2 (clk_llc2),
        .resetx   (resetx),
        .i_act    (w_act),
        .i_idx    (w_hidx),
        .i_cap    (r_cap),
        .i_y      (r_vpo[15:8]),
        .i_c      (r_vpo[7:0]),
        .o_emit   (w_emit),
        .o_y      (w_y),
        .o_cb     (w_cb),
        .o_cr     (w_cr)
    );

    // FSM state register.
    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) r_state <= ST_WAIT_VS;
        else         r_state <= w_next;
    end

    // Pixel and line counters; line capture decided at each href rise.
    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_cap  <= 1'b0;
            r_line <= 7'd0;
        end else begin
            if (w_act && (w_hidx <= H_LIM)) r_hcnt <= w_hidx + HW'(1);
            if (r_state == ST_WAIT_VS) begin
                r_vcnt <= '0;
                r_cap  <= 1'b0;
            end else if (w_line_start) begin
                r_cap  <= ~r_vcnt[0] & (r_vcnt < V_LIM);
                r_line <= 7'(r_vcnt >> 1);
                if (r_vcnt != V_LIM) r_vcnt <= r_vcnt + VW'(1);
            end
        end
    end

    // Registered outputs; pixel fields hold between strobes.
    always_ff @(posedge clk_llc2 or negedge resetx) begin
        if (!resetx) begin
            o_pix_valid <= 1'b0;
            o_pix_y     <= 8'd0;
            o_pix_cb    <= 8'd0;
            o_pix_cr    <= 8'd0;
            o_pix_x     <= 8'd0;
            o_pix_line  <= 7'd0;
            o_sof       <= 1'b0;
            o_eol       <= 1'b0;
            o_eof       <= 1'b0;
            o_line_err  <= 1'b0;
            o_field_cnt <= 8'd0;
            r_eof_pend  <= 1'b0;
        end else begin
            o_pix_valid <= w_emit;
            if (w_emit) begin
                o_pix_y    <= w_y;
                o_pix_cb   <= w_cb;
                o_pix_cr   <= w_cr;
                o_pix_x    <= w_x;
                o_pix_line <= r_line;
            end
            o_sof      <= w_emit & (w_x == 8'd0) & (r_line == 7'd0);
            o_eol      <= w_emit & (w_x == X_LAST);
            o_eof      <= w_eof_now;
            o_line_err <= w_lerr;
            r_eof_pend <= w_vend & w_emit;
            if (w_eof_now) o_field_cnt <= o_field_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_vcap_field_decimator.sv
module tb_vcap_field_decimator;

    localparam int H = 720;
    localparam int V = 12;

    logic        clk_llc2 = 1'b0;
    logic        resetx   = 1'b0;
    logic        vref     = 1'b0;
    logic        href     = 1'b0;
    logic        odd      = 1'b0;
    logic [15:0] vpo      = 16'd0;
    logic        pix_valid, sof, eol, eof, line_err;
    logic [7:0]  pix_y, pix_cb, pix_cr, pix_x, field_cnt;
    logic [6:0]  pix_line;

    vcap_field_decimator #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk_llc2    (clk_llc2),
        .resetx      (resetx),
        .i_vref      (vref),
        .i_href      (href),
        .i_odd       (odd),
        .i_vpo       (vpo),
        .o_pix_valid (pix_valid),
        .o_pix_y     (pix_y),
        .o_pix_cb    (pix_cb),
        .o_pix_cr    (pix_cr),
        .o_pix_x     (pix_x),
        .o_pix_line  (pix_line),
        .o_sof       (sof),
        .o_eol       (eol),
        .o_eof       (eof),
        .o_line_err  (line_err),
        .o_field_cnt (field_cnt)
    );

    always #5 clk_llc2 = ~clk_llc2;

    int cyc = 0;
    always @(posedge clk_llc2) cyc <= cyc + 1;

    typedef struct {
        int x; int line; int y; int cb; int cr; bit sof; bit eol; int cyc;
    } pix_t;

    pix_t exp_q[$];
    pix_t mon_e;
    int   n_checks = 0, n_pass = 0;
    int   obs_pix, obs_eof, obs_lerr, obs_eof_cyc;
    int   exp_pix, exp_eof, exp_lerr, exp_eof_cyc;
    int   exp_fcnt = 0;
    bit   cap_field = 1'b0;
    int   vl = 0;
    int   ys[0:1023], cs[0:1023], scyc[0:1023];

    // Scoreboard: every output pixel is matched in order against the model.
    always @(negedge clk_llc2) begin
        if (resetx) begin
            if (pix_valid) begin
                obs_pix++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pixel: unexpected x=%0d line=%0d at cyc %0d, required none", pix_x, pix_line, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (pix_x !== 8'(mon_e.x) || pix_line !== 7'(mon_e.line) || pix_y !== 8'(mon_e.y) ||
                        pix_cb !== 8'(mon_e.cb) || pix_cr !== 8'(mon_e.cr) || sof !== mon_e.sof ||
                        eol !== mon_e.eol || cyc != mon_e.cyc)
                        $display("FAIL pixel: got x=%0d ln=%0d y=%0h cb=%0h cr=%0h sof=%b eol=%b cyc=%0d, required x=%0d ln=%0d y=%0h cb=%0h cr=%0h sof=%b eol=%b cyc=%0d",
                                 pix_x, pix_line, pix_y, pix_cb, pix_cr, sof, eol, cyc,
                                 mon_e.x, mon_e.line, mon_e.y, mon_e.cb, mon_e.cr, mon_e.sof, mon_e.eol, mon_e.cyc);
                    else
                        n_pass++;
                end
            end
            if (eof) begin
                obs_eof++;
                obs_eof_cyc = cyc;
            end
            if (line_err) obs_lerr++;
        end
    end

    task automatic tick();
        @(posedge clk_llc2);
        #1;
    endtask

    task automatic clear_counts();
        obs_pix = 0; obs_eof = 0; obs_lerr = 0; obs_eof_cyc = -1;
        exp_pix = 0; exp_eof = 0; exp_lerr = 0; exp_eof_cyc = -1;
    endtask

    task automatic start_field(input bit odd_f);
        vref = 1'b0;
        href = 1'b0;
        repeat (4) tick();
        vref      = 1'b1;
        odd       = odd_f;
        cap_field = odd_f;
        vl        = 0;
        repeat (4) tick();
    endtask

    task automatic end_field();
        vref = 1'b0;
        href = 1'b0;
        if (cap_field) begin
            exp_eof++;
            exp_fcnt    = (exp_fcnt + 1) % 256;
            exp_eof_cyc = cyc + 2;
        end
        cap_field = 1'b0;
        repeat (6) tick();
    endtask

    // mode 0: normal line; 1: vref+href fall after len samples;
    // 2: vref falls together with the last sample; 3: leave href high.
    task automatic send_line(input int len, input int mode);
        bit capl;
        pix_t p;
        int g;
        capl = cap_field && (vl % 2 == 0) && (vl < V);
        for (int i = 0; i < len; i++) begin
            href  = 1'b1;
            ys[i] = int'($urandom_range(0, 255));
            cs[i] = int'($urandom_range(0, 255));
            vpo   = {8'(ys[i]), 8'(cs[i])};
            if (mode == 2 && i == len - 1) vref = 1'b0;
            scyc[i] = cyc;
            if (capl && (i % 4 == 3) && (i < H)) begin
                g     = i / 4;
`ifdef VCAP_LUMA_AVG_EN
                p.y   = (ys[i-3] + ys[i-2] + ys[i-1] + ys[i] + 2) / 4;
`else
                p.y   = ys[i-3];
`endif
                p.x   = g;
                p.line = vl / 2;
                p.cb  = cs[i-3];
                p.cr  = cs[i-2];
                p.sof = (g == 0) && (vl == 0);
                p.eol = (g == H / 4 - 1);
                p.cyc = cyc + 2;
                exp_q.push_back(p);
                exp_pix++;
            end
            tick();
        end
        if (capl && mode == 0 && len != H) exp_lerr++;
        if (mode == 1) begin
            vref = 1'b0;
            href = 1'b0;
            if (cap_field) begin
                exp_eof++;
                exp_fcnt    = (exp_fcnt + 1) % 256;
                exp_eof_cyc = cyc + 2;
            end
            cap_field = 1'b0;
        end else if (mode == 2) begin
            href = 1'b0;
            if (cap_field) begin
                exp_eof++;
                exp_fcnt    = (exp_fcnt + 1) % 256;
                exp_eof_cyc = scyc[len-1] + 3;
            end
            cap_field = 1'b0;
        end else if (mode == 0) begin
            href = 1'b0;
        end
        vl++;
        if (mode != 3) repeat (4) tick();
    endtask

    task automatic test_reset();
        resetx = 1'b0;
        repeat (3) tick();
        n_checks++;
        if ({pix_valid, pix_y, pix_cb, pix_cr, pix_x, pix_line, sof, eol, eof, line_err, field_cnt} !== '0)
            $display("FAIL reset_outputs: got valid=%b y=%0h x=%0d fcnt=%0d, required all 0", pix_valid, pix_y, pix_x, field_cnt);
        else
            n_pass++;
        resetx = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_full_field();
        clear_counts();
        start_field(1'b1);
        for (int l = 0; l < V + 1; l++) send_line(H, 0);
        end_field();
        n_checks++;
        if (obs_pix !== exp_pix || exp_pix != (V / 2) * (H / 4)) $display("FAIL full_pix_count: got %0d, required %0d", obs_pix, exp_pix);
        else n_pass++;
        n_checks++;
        if (obs_eof !== exp_eof || obs_eof_cyc !== exp_eof_cyc) $display("FAIL full_eof: got %0d@%0d, required %0d@%0d", obs_eof, obs_eof_cyc, exp_eof, exp_eof_cyc);
        else n_pass++;
        n_checks++;
        if (obs_lerr !== exp_lerr) $display("FAIL full_line_err: got %0d, required %0d", obs_lerr, exp_lerr);
        else n_pass++;
        n_checks++;
        if (field_cnt !== 8'(exp_fcnt)) $display("FAIL full_field_cnt: got %0d, required %0d", field_cnt, exp_fcnt);
        else n_pass++;
    endtask

    task automatic test_even_then_odd();
        clear_counts();
        start_field(1'b0);
        for (int l = 0; l < 4; l++) send_line(H, 0);
        end_field();
        n_checks++;
        if (obs_pix !== 0 || obs_eof !== 0) $display("FAIL even_ignored: got pix=%0d eof=%0d, required 0 0", obs_pix, obs_eof);
        else n_pass++;
        start_field(1'b1);
        for (int l = 0; l < 4; l++) send_line(H, 0);
        end_field();
        n_checks++;
        if (obs_pix !== exp_pix) $display("FAIL odd_pix_count: got %0d, required %0d", obs_pix, exp_pix);
        else n_pass++;
        n_checks++;
        if (obs_eof !== exp_eof || obs_eof_cyc !== exp_eof_cyc) $display("FAIL odd_eof: got %0d@%0d, required %0d@%0d", obs_eof, obs_eof_cyc, exp_eof, exp_eof_cyc);
        else n_pass++;
        n_checks++;
        if (field_cnt !== 8'(exp_fcnt)) $display("FAIL odd_field_cnt: got %0d, required %0d", field_cnt, exp_fcnt);
        else n_pass++;
    endtask

    task automatic test_short_long();
        clear_counts();
        start_field(1'b1);
        for (int l = 0; l < V + 1; l++) begin
            if (l == 10)      send_line(H - 5, 0);
            else if (l == 4)  send_line(H + 10, 0);
            else if (l == V)  send_line(H - 40, 0);
            else              send_line(H, 0);
        end
        end_field();
        n_checks++;
        if (obs_pix !== exp_pix) $display("FAIL shortlong_pix_count: got %0d, required %0d", obs_pix, exp_pix);
        else n_pass++;
        n_checks++;
        if (obs_lerr !== exp_lerr || exp_lerr != 2) $display("FAIL shortlong_line_err: got %0d, required %0d", obs_lerr, exp_lerr);
        else n_pass++;
        n_checks++;
        if (obs_eof !== exp_eof || obs_eof_cyc !== exp_eof_cyc) $display("FAIL shortlong_eof: got %0d@%0d, required %0d@%0d", obs_eof, obs_eof_cyc, exp_eof, exp_eof_cyc);
        else n_pass++;
    endtask

    task automatic test_abort();
        clear_counts();
        start_field(1'b1);
        for (int l = 0; l < 4; l++) send_line(H, 0);
        send_line(301, 1);
        n_checks++;
        if (obs_eof !== 1 || obs_eof_cyc !== exp_eof_cyc || obs_lerr !== 0)
            $display("FAIL abort_eof: got eof=%0d@%0d lerr=%0d, required 1@%0d lerr=0", obs_eof, obs_eof_cyc, obs_lerr, exp_eof_cyc);
        else n_pass++;
        start_field(1'b1);
        for (int l = 0; l < 2; l++) send_line(H, 0);
        end_field();
        n_checks++;
        if (obs_pix !== exp_pix) $display("FAIL abort_pix_count: got %0d, required %0d", obs_pix, exp_pix);
        else n_pass++;
        n_checks++;
        if (field_cnt !== 8'(exp_fcnt)) $display("FAIL abort_field_cnt: got %0d, required %0d", field_cnt, exp_fcnt);
        else n_pass++;
    endtask

    task automatic test_vref_with_last_sample();
        clear_counts();
        start_field(1'b1);
        send_line(H, 2);
        repeat (4) tick();
        n_checks++;
        if (obs_pix !== exp_pix || obs_eof !== 1 || obs_eof_cyc !== exp_eof_cyc)
            $display("FAIL last_sample_eof: got pix=%0d eof=%0d@%0d, required pix=%0d eof=1@%0d", obs_pix, obs_eof, obs_eof_cyc, exp_pix, exp_eof_cyc);
        else n_pass++;
    endtask

    task automatic test_reset_mid_field();
        clear_counts();
        start_field(1'b1);
        send_line(H, 0);
        send_line(200, 3);
        resetx = 1'b0;
        #1;
        n_checks++;
        if ({pix_valid, pix_y, pix_cb, pix_cr, pix_x, pix_line, sof, eol, eof, line_err, field_cnt} !== '0)
            $display("FAIL midreset_outputs: got y=%0h cb=%0h x=%0d fcnt=%0d, required all 0", pix_y, pix_cb, pix_x, field_cnt);
        else n_pass++;
        cap_field = 1'b0;
        exp_fcnt  = 0;
        repeat (3) tick();
        resetx = 1'b1;
        repeat (20) tick();
        href = 1'b0;
        repeat (4) tick();
        for (int l = 0; l < 2; l++) send_line(H, 0);
        end_field();
        n_checks++;
        if (obs_pix !== exp_pix || obs_eof !== 0 || obs_lerr !== 0)
            $display("FAIL midreset_quiet: got pix=%0d eof=%0d lerr=%0d, required pix=%0d eof=0 lerr=0", obs_pix, obs_eof, obs_lerr, exp_pix);
        else n_pass++;
        start_field(1'b1);
        for (int l = 0; l < 2; l++) send_line(H, 0);
        end_field();
        n_checks++;
        if (obs_pix !== exp_pix || field_cnt !== 8'(exp_fcnt) || exp_fcnt != 1)
            $display("FAIL midreset_restart: got pix=%0d fcnt=%0d, required pix=%0d fcnt=%0d", obs_pix, field_cnt, exp_pix, exp_fcnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_field();
        test_even_then_odd();
        test_short_long();
        test_abort();
        test_vref_with_last_sample();
        test_reset_mid_field();
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL leftover_pixels: got %0d missing, required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
